// File: rtl/fir_dec_pkg.sv
// Shared helpers for the integrate-and-dump decimator: derived widths and
// the round-half-up / saturate scaler applied to each dumped sum.
package fir_dec_pkg;

  function automatic int acc_w_of(input int din_w, input int dec_log2);
    return din_w + dec_log2;
  endfunction

  function automatic int sh_of(input int din_w, input int dec_log2, input int dout_w);
    return din_w + dec_log2 - dout_w;
  endfunction

  // Works at 64 bits so the +half rounding term can never wrap the sum.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] sum,
                                                   input int sh, input int dout_w);
    logic signed [63:0] rnd;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rnd = sum;
    if (sh > 0) rnd = (sum + (64'sd1 <<< (sh - 1))) >>> sh;
    hi  = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dout_w - 1));
    if (rnd > hi) return hi;
    if (rnd < lo) return lo;
    return rnd;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Circular FIFO whose read side comes straight from registered storage, so
// the consumer's ready never reaches the outputs combinationally.
module axis_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop & (count != '0);
  // A push on a full FIFO is accepted only when the same cycle frees a slot.
  assign do_push = push & ((count != (AW+1)'(DEPTH)) | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/fir_dec_axis_out.sv
// Integrate-and-dump decimator behind fir_top: averages groups of 2**DEC_LOG2
// samples, rounds/saturates, and streams results out on AXIS with framed TLAST.
module fir_dec_axis_out
  import fir_dec_pkg::*;
#(
  parameter int DIN_W      = 16,
  parameter int DOUT_W     = 16,
  parameter int DEC_LOG2   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_LEN  = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [DIN_W-1:0]              in_data,
  input  logic                          in_valid,
  output logic [DOUT_W-1:0]             m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int ACC_W = acc_w_of(DIN_W, DEC_LOG2);
  localparam int SH    = sh_of(DIN_W, DEC_LOG2, DOUT_W);
  localparam int FC_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef struct packed {
    logic              tlast;
    logic [DOUT_W-1:0] data;
  } fifo_entry_t;

  logic [DEC_LOG2-1:0]     phase;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] ext_in;
  logic signed [ACC_W-1:0] sum;
  logic [DOUT_W-1:0]       dump_q;
  logic                    dump_vld;
  logic [FC_W-1:0]         fcnt;
  logic                    frame_end;
  logic                    samp;
  logic                    dump_now;
  logic                    pop;
  logic                    full;
  logic                    empty;
  fifo_entry_t             wr_entry;
  fifo_entry_t             rd_entry;

  assign samp      = in_valid & en;
  assign dump_now  = samp & (&phase);
  assign ext_in    = ACC_W'($signed(in_data));
  assign sum       = acc + ext_in;
  assign frame_end = (fcnt == FC_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      acc   <= '0;
    end else if (!en) begin
      phase <= '0;
      acc   <= '0;
    end else if (in_valid) begin
      phase <= phase + 1'b1;
      acc   <= (phase == '0) ? ext_in : sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_vld <= 1'b0;
      dump_q   <= '0;
    end else begin
      dump_vld <= dump_now;
      if (dump_now) dump_q <= DOUT_W'(sat_round(64'(sum), SH, DOUT_W));
    end
  end

  // The frame counter advances on every write attempt, including dropped
  // ones, so TLAST stays aligned to the write count across overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
    end else if (!en) begin
      fcnt <= '0;
    end else if (dump_vld) begin
      fcnt <= frame_end ? '0 : fcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end else if (dump_vld & full & !pop) begin
      ovf <= 1'b1;
    end
  end

  always_comb begin
    wr_entry       = '0;
    wr_entry.tlast = frame_end;
    wr_entry.data  = dump_q;
  end

  assign pop = m_tvalid & m_tready;

  axis_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DOUT_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (dump_vld),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign m_tvalid = !empty;
  assign m_tdata  = rd_entry.data;
  assign m_tlast  = rd_entry.tlast;

endmodule

// File: tb/tb_fir_dec_axis_out.sv
// Directed bench for fir_dec_axis_out: main instance with FRAME_LEN=8 plus
// 17/18-bit output instances sharing the input stream for scaling checks.
module tb_fir_dec_axis_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, in_valid, m_tready, ovf_clr;
  logic [15:0] in_data;
  logic [15:0] m_tdata;
  logic        m_tvalid, m_tlast, ovf;
  logic [2:0]  fifo_level;
  logic [16:0] d17;
  logic        v17, l17, o17;
  logic [2:0]  f17;
  logic [17:0] d18;
  logic        v18, l18, o18;
  logic [2:0]  f18;

  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] got_q[$];
  longint last17 = 0;
  longint last18 = 0;

  fir_dec_axis_out #(.DIN_W(16), .DOUT_W(16), .DEC_LOG2(2), .FIFO_DEPTH(4), .FRAME_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .fifo_level(fifo_level), .ovf(ovf), .ovf_clr(ovf_clr));

  fir_dec_axis_out #(.DIN_W(16), .DOUT_W(17), .DEC_LOG2(2), .FIFO_DEPTH(4), .FRAME_LEN(8)) dut17 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
    .m_tdata(d17), .m_tvalid(v17), .m_tready(1'b1), .m_tlast(l17),
    .fifo_level(f17), .ovf(o17), .ovf_clr(ovf_clr));

  fir_dec_axis_out #(.DIN_W(16), .DOUT_W(18), .DEC_LOG2(2), .FIFO_DEPTH(4), .FRAME_LEN(8)) dut18 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
    .m_tdata(d18), .m_tvalid(v18), .m_tready(1'b1), .m_tlast(l18),
    .fifo_level(f18), .ovf(o18), .ovf_clr(ovf_clr));

  // Inputs only change just after posedge, so a negedge valid&ready is the handshake.
  always @(negedge clk) begin
    if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
    if (v17) last17 = longint'($signed(d17));
    if (v18) last18 = longint'($signed(d18));
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_data  = 16'(v);
    in_valid = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0;
    m_tready = 1'b1; ovf_clr = 1'b0;
    step(); step();
    got_q.delete();
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  function automatic longint q_data(input int i);
    logic [15:0] d;
    d = got_q[i][15:0];
    return longint'($signed(d));
  endfunction

  initial begin
    int first_idx;
    int beats;

    // Reset state
    do_reset();
    check_val("rst_tvalid", longint'(m_tvalid), 0);
    check_val("rst_tdata",  longint'(m_tdata), 0);
    check_val("rst_tlast",  longint'(m_tlast), 0);
    check_val("rst_level",  longint'(fifo_level), 0);
    check_val("rst_ovf",    longint'(ovf), 0);

    // 1: constant 1000, first beat two cycles after the 4th sample, then every 4th
    first_idx = -1;
    beats     = 0;
    in_data   = 16'd1000;
    in_valid  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (m_tvalid) begin
        beats++;
        if (first_idx < 0) first_idx = i;
        check_val("const_data", longint'($signed(m_tdata)), 1000);
      end
    end
    check_val("const_first", first_idx, 5);
    check_val("const_beats", beats, 3);
    idle(4);

    // 2: rounding, positive and negative
    do_reset();
    send(1); send(2); send(3); send(4);
    send(-1); send(-1); send(-1); send(-2);
    idle(4);
    check_val("ramp_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check_val("ramp_pos", q_data(0), 3);
      check_val("ramp_neg", q_data(1), -1);
    end

    // 3: scaling/saturation on 16, 17 and 18 bit outputs
    do_reset();
    repeat (4) send(32767);
    idle(3);
    check_val("sat_max16", (got_q.size() > 0) ? q_data(0) : 0, 32767);
    check_val("sat_max17", last17, 65534);
    check_val("sat_max18", last18, 131068);
    repeat (4) send(-32768);
    idle(3);
    check_val("sat_min16", (got_q.size() > 1) ? q_data(1) : 0, -32768);
    check_val("sat_min17", last17, -65536);
    check_val("sat_min18", last18, -131072);

    // 4/5: stall 40 samples -> FIFO full, drops, then drain and keep framing
    do_reset();
    m_tready = 1'b0;
    for (int g = 0; g < 10; g++) repeat (4) send(100 * (g + 1));
    idle(3);
    check_val("stall_level", longint'(fifo_level), 4);
    check_val("stall_ovf",   longint'(ovf), 1);
    check_val("stall_tvalid", longint'(m_tvalid), 1);
    check_val("stall_hold",  longint'($signed(m_tdata)), 100);
    idle(5);
    check_val("stall_hold2", longint'($signed(m_tdata)), 100);
    m_tready = 1'b1;
    idle(6);
    for (int g = 10; g < 18; g++) repeat (4) send(100 * (g + 1));
    idle(4);
    check_val("drop_count", got_q.size(), 12);
    if (got_q.size() == 12) begin
      for (int i = 0; i < 4; i++) check_val("drain_data", q_data(i), 100 * (i + 1));
      for (int i = 4; i < 12; i++) begin
        check_val("drop_data", q_data(i), 100 * (i + 7));
        check_val("drop_tlast", longint'(got_q[i][16]), (i == 9) ? 1 : 0);
      end
    end
    check_val("ovf_sticky", longint'(ovf), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_val("ovf_clr", longint'(ovf), 0);

    // 5: continuous flow, TLAST on beats 7, 15, 23
    do_reset();
    for (int g = 0; g < 24; g++) repeat (4) send(g + 1);
    idle(4);
    check_val("frame_count", got_q.size(), 24);
    if (got_q.size() == 24) begin
      for (int i = 0; i < 24; i++) begin
        check_val("frame_tlast", longint'(got_q[i][16]), (i % 8 == 7) ? 1 : 0);
        check_val("frame_data", q_data(i), i + 1);
      end
    end

    // 6: en drop discards the partial group
    do_reset();
    send(5000); send(5000);
    in_valid = 1'b0;
    en = 1'b0;
    step();
    en = 1'b1;
    repeat (4) send(8);
    idle(4);
    check_val("en_count", got_q.size(), 1);
    check_val("en_data", (got_q.size() > 0) ? q_data(0) : 0, 8);

    // 6: asynchronous reset mid-frame clears FIFO and ovf
    m_tready = 1'b0;
    repeat (20) send(50);
    send(50); send(50);
    idle(1);
    check_val("pre_rst_ovf", longint'(ovf), 1);
    check_val("pre_rst_tvalid", longint'(m_tvalid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("arst_tvalid", longint'(m_tvalid), 0);
    check_val("arst_tdata",  longint'(m_tdata), 0);
    check_val("arst_level",  longint'(fifo_level), 0);
    check_val("arst_ovf",    longint'(ovf), 0);
    step();
    got_q.delete();
    rst_n = 1'b1;
    m_tready = 1'b1;
    idle(10);
    check_val("post_rst_beats", got_q.size(), 0);
    check_val("post_rst_tvalid", longint'(m_tvalid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
